// File: rtl/pwm_pkg.sv
// Shared types and reset constants for the multi-channel PWM generator.
package pwm_pkg;

   localparam int CTR_SIZE = 8;
   localparam int CHANNELS = 4;

   typedef logic [CTR_SIZE-1:0] ctr_t;

   typedef enum logic {
      DIR_UP,
      DIR_DOWN
   } dir_e;

   localparam ctr_t CTR_RESET = '0;
   localparam ctr_t TOP_RESET = '1;

endpackage

// File: rtl/pwm_multi_if.sv
// Control/status bundle between a register block (master) and pwm_multi (slave).
// The center signal exists only when PWM_CENTER_EN is defined.
interface pwm_multi_if #(
   parameter int CTR_SIZE = pwm_pkg::CTR_SIZE,
   parameter int CHANNELS = pwm_pkg::CHANNELS
);

   logic                         enable;
   logic [CTR_SIZE-1:0]          top;
   logic [CHANNELS*CTR_SIZE-1:0] compare;
   logic                         load;
   logic                         load_pending;
   logic                         period_end;
   logic [CHANNELS-1:0]          pwm;

`ifdef PWM_CENTER_EN
   logic                         center;

   modport master (output enable, top, compare, load, center,
                   input  load_pending, period_end, pwm);
   modport slave  (input  enable, top, compare, load, center,
                   output load_pending, period_end, pwm);
`else
   modport master (output enable, top, compare, load,
                   input  load_pending, period_end, pwm);
   modport slave  (input  enable, top, compare, load,
                   output load_pending, period_end, pwm);
`endif

endinterface

// File: rtl/pwm_channel.sv
// One PWM output: active compare register (reloaded on the apply strobe)
// and the registered comparison against the shared counter.
module pwm_channel #(
   parameter int CTR_SIZE = pwm_pkg::CTR_SIZE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                apply,
   input  logic [CTR_SIZE-1:0] ctr,
   input  logic [CTR_SIZE-1:0] cmp_sh,
   output logic                pwm
);

   logic [CTR_SIZE-1:0] cmp_act_d, cmp_act_q;
   logic                pwm_d, pwm_q;

   // The output compares against the compare value active before this edge,
   // so a reload at the boundary only affects the following period.
   always_comb begin
      cmp_act_d = apply ? cmp_sh : cmp_act_q;
      pwm_d     = enable && (ctr < cmp_act_q);
   end

   // NOTE: flops use non-blocking <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_act_q <= '0;
         pwm_q     <= 1'b0;
      end else begin
         cmp_act_q <= cmp_act_d;
         pwm_q     <= pwm_d;
      end
   end

   assign pwm = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared period counter and double-buffered top/compare.
// Optional centre-aligned counting is built when PWM_CENTER_EN is defined.
module pwm_multi #(
   parameter int CTR_SIZE = pwm_pkg::CTR_SIZE,
   parameter int CHANNELS = pwm_pkg::CHANNELS
) (
   input logic        clk,
   input logic        rst,
   pwm_multi_if.slave bus
);

   import pwm_pkg::*;

   localparam logic [CTR_SIZE-1:0] CTR_INIT = {CTR_SIZE{CTR_RESET[0]}};
   localparam logic [CTR_SIZE-1:0] TOP_INIT = {CTR_SIZE{TOP_RESET[0]}};
   localparam logic [CTR_SIZE-1:0] CTR_ONE  = CTR_SIZE'(1);

   logic [CTR_SIZE-1:0]          ctr_d, ctr_q;
   logic [CTR_SIZE-1:0]          top_act_d, top_act_q;
   logic [CTR_SIZE-1:0]          top_sh_d, top_sh_q;
   logic [CHANNELS*CTR_SIZE-1:0] cmp_sh_d, cmp_sh_q;
   logic                         load_pending_d, load_pending_q;
   logic                         period_end_d, period_end_q;
   logic                         boundary;
   logic                         apply;
   logic [CHANNELS-1:0]          pwm_w;

`ifdef PWM_CENTER_EN
   dir_e dir_d, dir_q;
   logic center_d, center_q;
`endif

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      top_sh_d       = top_sh_q;
      cmp_sh_d       = cmp_sh_q;
      load_pending_d = load_pending_q;
      ctr_d          = ctr_q;

`ifdef PWM_CENTER_EN
      if (center_q) begin
         boundary = bus.enable && ((dir_q == DIR_DOWN && ctr_q == '0) || top_act_q == '0);
      end else begin
         boundary = bus.enable && (ctr_q == top_act_q);
      end
`else
      boundary = bus.enable && (ctr_q == top_act_q);
`endif

      // While stopped a pending shadow is applied immediately.
      apply        = load_pending_q && (boundary || !bus.enable);
      top_act_d    = apply ? top_sh_q : top_act_q;
      period_end_d = boundary;

      // A load on the apply cycle keeps pending set for the next boundary.
      if (bus.load) begin
         top_sh_d       = bus.top;
         cmp_sh_d       = bus.compare;
         load_pending_d = 1'b1;
      end else if (apply) begin
         load_pending_d = 1'b0;
      end

`ifdef PWM_CENTER_EN
      center_d = (boundary || !bus.enable) ? bus.center : center_q;
      dir_d    = dir_q;
      if (!bus.enable) begin
         ctr_d = CTR_INIT;
         dir_d = DIR_UP;
      end else if (boundary) begin
         // The boundary cycle itself is the ctr==0 step of the down slope.
         dir_d = DIR_UP;
         ctr_d = (center_d && top_act_d != '0) ? CTR_ONE : CTR_INIT;
      end else if (!center_q) begin
         ctr_d = ctr_q + CTR_ONE;
      end else if (dir_q == DIR_UP && ctr_q == top_act_q) begin
         dir_d = DIR_DOWN;
         ctr_d = ctr_q - CTR_ONE;
      end else if (dir_q == DIR_UP) begin
         ctr_d = ctr_q + CTR_ONE;
      end else begin
         ctr_d = ctr_q - CTR_ONE;
      end
`else
      if (!bus.enable || boundary) begin
         ctr_d = CTR_INIT;
      end else begin
         ctr_d = ctr_q + CTR_ONE;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctr_q          <= CTR_INIT;
         top_act_q      <= TOP_INIT;
         top_sh_q       <= '0;
         cmp_sh_q       <= '0;
         load_pending_q <= 1'b0;
         period_end_q   <= 1'b0;
`ifdef PWM_CENTER_EN
         dir_q          <= DIR_UP;
         center_q       <= 1'b0;
`endif
      end else begin
         ctr_q          <= ctr_d;
         top_act_q      <= top_act_d;
         top_sh_q       <= top_sh_d;
         cmp_sh_q       <= cmp_sh_d;
         load_pending_q <= load_pending_d;
         period_end_q   <= period_end_d;
`ifdef PWM_CENTER_EN
         dir_q          <= dir_d;
         center_q       <= center_d;
`endif
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      pwm_channel #(.CTR_SIZE(CTR_SIZE)) u_ch (
         .clk    (clk),
         .rst    (rst),
         .enable (bus.enable),
         .apply  (apply),
         .ctr    (ctr_q),
         .cmp_sh (cmp_sh_q[i*CTR_SIZE +: CTR_SIZE]),
         .pwm    (pwm_w[i])
      );
   end

   assign bus.pwm          = pwm_w;
   assign bus.load_pending = load_pending_q;
   assign bus.period_end   = period_end_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios plus random traffic,
// all compared against a period-position reference model.
module tb_pwm_multi;

   localparam int CW = 8;
   localparam int CH = 4;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   pwm_multi_if #(.CTR_SIZE(CW), .CHANNELS(CH)) bus ();

   pwm_multi #(.CTR_SIZE(CW), .CHANNELS(CH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: position inside the current period plus the settings in force.
   int          m_phase  = 0;
   int          m_top    = 255;
   int          m_sh_top = 0;
   int          m_cmp    [CH];
   int          m_sh_cmp [CH];
   bit          m_pend   = 1'b0;
   bit          m_pe     = 1'b0;
   bit [CH-1:0] m_pwm    = '0;

   task automatic model_step();
      bit at_end;
      bit take;
      if (rst) begin
         m_phase  = 0;
         m_top    = 255;
         m_sh_top = 0;
         for (int i = 0; i < CH; i++) begin
            m_cmp[i]    = 0;
            m_sh_cmp[i] = 0;
         end
         m_pend = 1'b0;
         m_pe   = 1'b0;
         m_pwm  = '0;
      end else begin
         at_end = bus.enable && (m_phase == m_top);
         for (int i = 0; i < CH; i++) m_pwm[i] = bus.enable && (m_phase < m_cmp[i]);
         m_pe = at_end;
         take = m_pend && (at_end || !bus.enable);
         if (take) begin
            m_top = m_sh_top;
            for (int i = 0; i < CH; i++) m_cmp[i] = m_sh_cmp[i];
         end
         if (bus.load) begin
            m_sh_top = int'(bus.top);
            for (int i = 0; i < CH; i++) m_sh_cmp[i] = int'(bus.compare[i*CW +: CW]);
            m_pend = 1'b1;
         end else if (take) begin
            m_pend = 1'b0;
         end
         m_phase = (!bus.enable || at_end) ? 0 : m_phase + 1;
      end
   endtask

   function automatic logic [CH+1:0] exp_out();
      return {m_pwm, m_pe, m_pend};
   endfunction

   function automatic logic [CH+1:0] obs();
      return {bus.pwm, bus.period_end, bus.load_pending};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_load(input int t, input logic [CH*CW-1:0] c);
      bus.top     = t[CW-1:0];
      bus.compare = c;
      bus.load    = 1'b1;
      tick();
      bus.load    = 1'b0;
   endtask

   task automatic wait_clear(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 600; k++) begin
         tick();
         if (bus.load_pending == 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_pe(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 600; k++) begin
         tick();
         if (bus.period_end == 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      bus.enable  = 1'b1;
      bus.load    = 1'b1;
      bus.top     = CW'($urandom);
      bus.compare = $urandom;
      repeat (3) begin
         tick();
         total++;
         if (obs() !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0", obs());
         end
      end
      rst        = 1'b0;
      bus.load   = 1'b0;
      bus.enable = 1'b0;
      tick();
      total++;
      if (obs() !== '0) begin
         bad++;
         $display("FAIL reset_idle got=%b want=0", obs());
      end
   endtask

   task automatic test_duty();
      logic [CH*CW-1:0] c;
      int highs = 0;
      int pes   = 0;
      c       = $urandom;
      c[7:0]  = 8'd64;
      bus.enable = 1'b1;
      do_load(255, c);
      repeat (300) begin
         tick();
         total++;
         if (obs() !== exp_out()) begin
            bad++;
            $display("FAIL duty_model t=%0t got=%b want=%b", $time, obs(), exp_out());
         end
      end
      total++;
      if (bus.load_pending !== 1'b0) begin
         bad++;
         $display("FAIL duty_pending_clear got=%b want=0", bus.load_pending);
      end
      repeat (256) begin
         tick();
         highs += int'(bus.pwm[0]);
         pes   += int'(bus.period_end);
      end
      total++;
      if (highs != 64) begin
         bad++;
         $display("FAIL duty_high_count got=%0d want=64", highs);
      end
      total++;
      if (pes != 1) begin
         bad++;
         $display("FAIL duty_period_end_count got=%0d want=1", pes);
      end
   endtask

   task automatic test_stuck();
      logic [CH*CW-1:0] c;
      bit ok;
      int pes = 0;
      c        = $urandom;
      c[7:0]   = 8'd0;
      c[15:8]  = 8'd255;
      do_load(254, c);
      wait_clear(ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL stuck_apply_timeout got=pending want=applied");
      end
      tick();
      repeat (3 * 255) begin
         tick();
         pes += int'(bus.period_end);
         total++;
         if (bus.pwm[1:0] !== 2'b10 || obs() !== exp_out()) begin
            bad++;
            $display("FAIL stuck_levels t=%0t got=%b want=%b pwm10=10", $time, obs(), exp_out());
         end
      end
      total++;
      if (pes != 3) begin
         bad++;
         $display("FAIL stuck_period_count got=%0d want=3", pes);
      end
   endtask

   task automatic test_midload();
      logic [CH*CW-1:0] c;
      bit ok;
      int cnt;
      c      = $urandom;
      c[7:0] = 8'd64;
      do_load(255, c);
      wait_clear(ok);
      wait_pe(ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL midload_wait_timeout got=no_period_end want=period_end");
      end
      c[7:0] = 8'd128;
      cnt = int'(bus.pwm[0]);
      for (int k = 0; k < 300; k++) begin
         if (k == 30) begin
            bus.top     = 8'd255;
            bus.compare = c;
            bus.load    = 1'b1;
         end
         tick();
         bus.load = 1'b0;
         total++;
         if (obs() !== exp_out()) begin
            bad++;
            $display("FAIL midload_model t=%0t got=%b want=%b", $time, obs(), exp_out());
         end
         if (bus.period_end) break;
         cnt += int'(bus.pwm[0]);
      end
      total++;
      if (cnt != 64) begin
         bad++;
         $display("FAIL midload_current_pulse got=%0d want=64", cnt);
      end
      cnt = int'(bus.pwm[0]);
      for (int k = 0; k < 300; k++) begin
         tick();
         if (bus.period_end) break;
         cnt += int'(bus.pwm[0]);
      end
      total++;
      if (cnt != 128) begin
         bad++;
         $display("FAIL midload_next_pulse got=%0d want=128", cnt);
      end
   endtask

   task automatic test_wrap_load();
      logic [CH*CW-1:0] c;
      bit ok;
      int cnt;
      c      = $urandom;
      c[7:0] = 8'd5;
      do_load(15, c);
      wait_clear(ok);
      c[7:0] = 8'd9;
      do_load(15, c);
      for (int k = 0; k < 40; k++) begin
         if (m_phase == m_top) break;
         tick();
      end
      c[7:0] = 8'd12;
      do_load(15, c);
      total++;
      if (bus.period_end !== 1'b1 || bus.load_pending !== 1'b1) begin
         bad++;
         $display("FAIL wrap_load_edge got=pe%b lp%b want=pe1 lp1", bus.period_end, bus.load_pending);
      end
      cnt = int'(bus.pwm[0]);
      for (int k = 0; k < 40; k++) begin
         tick();
         if (bus.period_end) break;
         cnt += int'(bus.pwm[0]);
         total++;
         if (bus.load_pending !== 1'b1 || obs() !== exp_out()) begin
            bad++;
            $display("FAIL wrap_load_hold got=%b want=%b", obs(), exp_out());
         end
      end
      total++;
      if (cnt != 9) begin
         bad++;
         $display("FAIL wrap_load_old_shadow got=%0d want=9", cnt);
      end
      total++;
      if (bus.load_pending !== 1'b0) begin
         bad++;
         $display("FAIL wrap_load_clear got=%b want=0", bus.load_pending);
      end
      cnt = int'(bus.pwm[0]);
      for (int k = 0; k < 40; k++) begin
         tick();
         if (bus.period_end) break;
         cnt += int'(bus.pwm[0]);
      end
      total++;
      if (cnt != 12) begin
         bad++;
         $display("FAIL wrap_load_new_shadow got=%0d want=12", cnt);
      end
   endtask

   task automatic test_top0_enable_rst();
      logic [CH*CW-1:0] c;
      bit ok;
      int cnt;
      c       = $urandom;
      c[7:0]  = 8'd1;
      c[15:8] = 8'd0;
      do_load(0, c);
      wait_clear(ok);
      tick();
      repeat (10) begin
         tick();
         total++;
         if (bus.period_end !== 1'b1 || bus.pwm[1:0] !== 2'b01) begin
            bad++;
            $display("FAIL top0_levels got=pe%b pwm%b want=pe1 pwm01", bus.period_end, bus.pwm[1:0]);
         end
      end
      bus.enable = 1'b0;
      tick();
      total++;
      if (bus.pwm !== '0 || bus.period_end !== 1'b0) begin
         bad++;
         $display("FAIL disable_outputs got=pe%b pwm%b want=0", bus.period_end, bus.pwm);
      end
      c[7:0] = 8'd5;
      do_load(255, c);
      tick();
      total++;
      if (bus.load_pending !== 1'b0) begin
         bad++;
         $display("FAIL stopped_apply got=%b want=0", bus.load_pending);
      end
      bus.enable = 1'b1;
      tick();
      total++;
      if (bus.pwm[0] !== 1'b1) begin
         bad++;
         $display("FAIL restart_first got=%b want=1", bus.pwm[0]);
      end
      cnt = int'(bus.pwm[0]);
      repeat (9) begin
         tick();
         cnt += int'(bus.pwm[0]);
      end
      total++;
      if (cnt != 5) begin
         bad++;
         $display("FAIL restart_from_zero got=%0d want=5", cnt);
      end
      repeat (40) tick();
      rst         = 1'b1;
      bus.compare = $urandom;
      bus.load    = 1'b1;
      tick();
      total++;
      if (obs() !== '0) begin
         bad++;
         $display("FAIL reset_mid_period got=%b want=0", obs());
      end
      rst      = 1'b0;
      bus.load = 1'b0;
   endtask

   task automatic test_random();
      repeat (3000) begin
         bus.enable = ($urandom_range(0, 15) != 0);
         bus.load   = ($urandom_range(0, 24) == 0);
         bus.top    = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(0, 20));
         for (int i = 0; i < CH; i++) bus.compare[i*CW +: CW] = CW'($urandom_range(0, 24));
         rst = ($urandom_range(0, 599) == 0);
         tick();
         total++;
         if (obs() !== exp_out()) begin
            bad++;
            $display("FAIL random_model t=%0t got=%b want=%b", $time, obs(), exp_out());
         end
      end
      rst      = 1'b0;
      bus.load = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      bus.enable  = 1'b0;
      bus.load    = 1'b0;
      bus.top     = '0;
      bus.compare = '0;
`ifdef PWM_CENTER_EN
      bus.center  = 1'b0;
`endif
      for (int i = 0; i < CH; i++) begin
         m_cmp[i]    = 0;
         m_sh_cmp[i] = 0;
      end
      test_reset();
      test_duty();
      test_stuck();
      test_midload();
      test_wrap_load();
      test_top0_enable_rst();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
